tl_ul_req_buffer: RTL and testbench
===================================

TL_UL_REQ_BUFFER -- requirements
Module: tl_ul_req_buffer

Interface
REQ-001 Parameter DEPTH, default 2: number of A-channel FIFO entries (power of two, at least 2).
REQ-002 Parameter MAX_INFLIGHT, default 4: maximum number of requests issued downstream without a D response yet delivered upstream (at least 1).
REQ-003 clock  in  1: the single clock.
REQ-004 reset  in  1: synchronous, active-high reset.
REQ-005 auto_in_a_valid/ready  in/out  1/1: upstream A-channel handshake.
REQ-006 auto_in_a_bits_opcode/param/size/source/address/mask/corrupt  in  3/3/2/12/15/4/1: upstream A-channel fields.
REQ-007 auto_in_a_bits_data  in  32: upstream A-channel data.
REQ-008 auto_out_a_valid/ready  out/in  1/1: downstream A-channel handshake.
REQ-009 auto_out_a_bits_*  out: the same fields and widths as REQ-006 and REQ-007, taken from the FIFO head.
REQ-010 auto_out_d_valid/ready  in/out  1/1: downstream D-channel handshake.
REQ-011 auto_out_d_bits_opcode/size/source/data/denied  in  3/2/12/32/1: downstream D-channel fields.
REQ-012 auto_in_d_valid/ready  out/in  1/1: upstream D-channel handshake.
REQ-013 auto_in_d_bits_*  out: the same fields and widths as REQ-011, taken from the D register.
REQ-014 busy  out  1: high when the FIFO is non-empty, the in-flight count is non-zero, or the D register is full.
REQ-015 err  out  1: sticky protocol-error flag.
REQ-016 err_code  out  2: cause of the first error (1 = illegal opcode, 2 = misaligned address, 3 = D underflow).

Function
REQ-017 The A FIFO shall be a circular buffer with read/write pointers and a count; auto_in_a_ready = (count != DEPTH), with no bypass when full.
REQ-018 An A beat accepted at edge N shall be visible on auto_out_a at cycle N+1 at the earliest, with no combinational path from in to out.
REQ-019 auto_out_a_valid = (FIFO non-empty) && (inflight < MAX_INFLIGHT).
REQ-020 Enqueue and dequeue in the same cycle shall leave count unchanged and advance both pointers; pointers wrap modulo DEPTH.
REQ-021 FIFO order shall be preserved exactly, and fields shall not be modified.
REQ-022 inflight shall have width clog2(MAX_INFLIGHT+1), increment on out_a fire, and decrement on in_d fire.
REQ-023 When out_a fire and in_d fire occur in the same cycle, inflight shall be unchanged.
REQ-024 When in_d fires with inflight == 0, inflight shall stay 0 (saturate).
REQ-025 The D path shall be a 1-entry register: auto_out_d_ready = !d_full || auto_in_d_ready, and auto_in_d_valid = d_full.
REQ-026 A D beat accepted at edge N shall appear upstream at cycle N+1.
REQ-027 A simultaneous in_d drain and out_d load shall replace the D register contents with no bubble.
REQ-028 While auto_in_d_valid is high and auto_in_d_ready is low, all auto_in_d_bits_* shall hold stable.
REQ-029 While auto_out_a_valid is high and auto_out_a_ready is low, all auto_out_a_bits_* shall hold stable.

Reset
REQ-030 While reset is high at a clock edge: pointers, count, inflight, d_full, err and err_code shall become 0.
REQ-031 After reset: auto_out_a_valid = 0, auto_in_d_valid = 0, busy = 0, and auto_in_a_ready = 1.
REQ-032 Reset asserted mid-transaction shall discard all buffered A and D beats with no further output beats.
REQ-033 Data storage shall not require reset.

Configuration
REQ-034 With TL_REQ_BUFFER_ERRFLAG_EN defined, each in_a fire shall be checked.
REQ-035 Checks: opcode not in {0, 1, 4} sets code 1; address[1:0] not aligned to 2^size sets code 2; REQ-024 underflow sets code 3.
REQ-036 err shall set on the first error and hold until reset; err_code shall capture only that first cause.
REQ-037 Offending beats shall still be forwarded unchanged.
REQ-038 Without TL_REQ_BUFFER_ERRFLAG_EN, err and err_code shall be constant 0 and no check logic shall be instantiated.

Verification
REQ-039 Back-to-back Gets with source 0x001..0x003, out_a_ready = 1 -> each appears on out_a one cycle after its fire, in order, and inflight reaches 3.
REQ-040 out_a_ready = 0 and 3 pushes with DEPTH = 2 -> in_a_ready falls after the 2nd fire; the 3rd beat is accepted only after the first dequeue.
REQ-041 5 requests with no D responses and MAX_INFLIGHT = 4 -> the 5th is held with out_a_valid = 0 until one in_d fire, then issues the next cycle.
REQ-042 in_d_ready = 0 then a D beat with data 0xDEADBEEF -> in_d_valid = 1 with the data stable; out_d_ready stays 0 until drained; simultaneous drain/load yields no bubble.
REQ-043 Macro defined, Put at address 0x0002 with size 2 -> err = 1 and err_code = 2 the next cycle; a later opcode 7 leaves err_code = 2. Macro undefined, same stimulus -> err = 0.
REQ-044 Reset pulsed with 2 queued A beats and d_full = 1 -> next cycle out_a_valid = 0, in_d_valid = 0, busy = 0, and in_a_ready = 1.

Source files
------------

// File: rtl/tl_ul_req_buffer.sv
// TL-UL request buffer: A-channel FIFO with in-flight limiter and a 1-entry D register.
// Define TL_REQ_BUFFER_ERRFLAG_EN to build the sticky protocol-error checker.
module tl_ul_req_buffer #(
  parameter int DEPTH        = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        auto_in_a_valid,
  output logic        auto_in_a_ready,
  input  logic [2:0]  auto_in_a_bits_opcode,
  input  logic [2:0]  auto_in_a_bits_param,
  input  logic [1:0]  auto_in_a_bits_size,
  input  logic [11:0] auto_in_a_bits_source,
  input  logic [14:0] auto_in_a_bits_address,
  input  logic [3:0]  auto_in_a_bits_mask,
  input  logic        auto_in_a_bits_corrupt,
  input  logic [31:0] auto_in_a_bits_data,
  output logic        auto_out_a_valid,
  input  logic        auto_out_a_ready,
  output logic [2:0]  auto_out_a_bits_opcode,
  output logic [2:0]  auto_out_a_bits_param,
  output logic [1:0]  auto_out_a_bits_size,
  output logic [11:0] auto_out_a_bits_source,
  output logic [14:0] auto_out_a_bits_address,
  output logic [3:0]  auto_out_a_bits_mask,
  output logic        auto_out_a_bits_corrupt,
  output logic [31:0] auto_out_a_bits_data,
  input  logic        auto_out_d_valid,
  output logic        auto_out_d_ready,
  input  logic [2:0]  auto_out_d_bits_opcode,
  input  logic [1:0]  auto_out_d_bits_size,
  input  logic [11:0] auto_out_d_bits_source,
  input  logic [31:0] auto_out_d_bits_data,
  input  logic        auto_out_d_bits_denied,
  output logic        auto_in_d_valid,
  input  logic        auto_in_d_ready,
  output logic [2:0]  auto_in_d_bits_opcode,
  output logic [1:0]  auto_in_d_bits_size,
  output logic [11:0] auto_in_d_bits_source,
  output logic [31:0] auto_in_d_bits_data,
  output logic        auto_in_d_bits_denied,
  output logic        busy,
  output logic        err,
  output logic [1:0]  err_code
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam int AW = 72;
  localparam int DW = 50;

  logic [AW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic [IW-1:0] r_inflight;
  logic [DW-1:0] r_d;
  logic          r_d_full;

  logic w_in_a_fire, w_out_a_fire, w_out_d_fire, w_in_d_fire;

  assign auto_in_a_ready  = (r_count != CW'(DEPTH));
  assign auto_out_a_valid = (r_count != '0) && (r_inflight < IW'(MAX_INFLIGHT));
  assign auto_out_d_ready = !r_d_full || auto_in_d_ready;
  assign auto_in_d_valid  = r_d_full;

  assign w_in_a_fire  = auto_in_a_valid && auto_in_a_ready;
  assign w_out_a_fire = auto_out_a_valid && auto_out_a_ready;
  assign w_out_d_fire = auto_out_d_valid && auto_out_d_ready;
  assign w_in_d_fire  = r_d_full && auto_in_d_ready;

  assign busy = (r_count != '0) || (r_inflight != '0) || r_d_full;

  // Outputs come only from registered storage, so no in->out combinational path.
  assign {auto_out_a_bits_opcode, auto_out_a_bits_param, auto_out_a_bits_size,
          auto_out_a_bits_source, auto_out_a_bits_address, auto_out_a_bits_mask,
          auto_out_a_bits_corrupt, auto_out_a_bits_data} = r_mem[r_rptr];

  assign {auto_in_d_bits_opcode, auto_in_d_bits_size, auto_in_d_bits_source,
          auto_in_d_bits_data, auto_in_d_bits_denied} = r_d;

  always_ff @(posedge clock) begin
    if (w_in_a_fire)
      r_mem[r_wptr] <= {auto_in_a_bits_opcode, auto_in_a_bits_param, auto_in_a_bits_size,
                        auto_in_a_bits_source, auto_in_a_bits_address, auto_in_a_bits_mask,
                        auto_in_a_bits_corrupt, auto_in_a_bits_data};
    if (w_out_d_fire)
      r_d <= {auto_out_d_bits_opcode, auto_out_d_bits_size, auto_out_d_bits_source,
              auto_out_d_bits_data, auto_out_d_bits_denied};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_d_full   <= 1'b0;
    end else begin
      if (w_in_a_fire)  r_wptr <= r_wptr + 1'b1;
      if (w_out_a_fire) r_rptr <= r_rptr + 1'b1;
      if (w_in_a_fire && !w_out_a_fire)      r_count <= r_count + 1'b1;
      else if (!w_in_a_fire && w_out_a_fire) r_count <= r_count - 1'b1;
      // A response with nothing outstanding saturates at zero.
      if (w_out_a_fire && !w_in_d_fire)                            r_inflight <= r_inflight + 1'b1;
      else if (!w_out_a_fire && w_in_d_fire && r_inflight != '0)   r_inflight <= r_inflight - 1'b1;
      if (w_out_d_fire)     r_d_full <= 1'b1;
      else if (w_in_d_fire) r_d_full <= 1'b0;
    end
  end

`ifdef TL_REQ_BUFFER_ERRFLAG_EN
  logic       r_err;
  logic [1:0] r_err_code;
  logic [1:0] w_cause;
  logic       w_bad_op, w_misalign;

  assign w_bad_op   = !(auto_in_a_bits_opcode == 3'd0 || auto_in_a_bits_opcode == 3'd1 ||
                        auto_in_a_bits_opcode == 3'd4);
  assign w_misalign = ((auto_in_a_bits_size == 2'd1) && auto_in_a_bits_address[0]) ||
                      ((auto_in_a_bits_size[1]) && (auto_in_a_bits_address[1:0] != 2'd0));

  always_comb begin
    w_cause = 2'd0;
    if (w_in_a_fire && w_bad_op)        w_cause = 2'd1;
    else if (w_in_a_fire && w_misalign) w_cause = 2'd2;
    else if (w_in_d_fire && r_inflight == '0) w_cause = 2'd3;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_err      <= 1'b0;
      r_err_code <= 2'd0;
    end else if (!r_err && w_cause != 2'd0) begin
      r_err      <= 1'b1;
      r_err_code <= w_cause;
    end
  end

  assign err      = r_err;
  assign err_code = r_err_code;
`else
  assign err      = 1'b0;
  assign err_code = 2'd0;
`endif

endmodule

// File: tb/tb_tl_ul_req_buffer.sv
// Scoreboard bench for tl_ul_req_buffer: stimulus pushes expected beats, a monitor pops them.
module tb_tl_ul_req_buffer;
  logic        clock = 1'b0;
  logic        reset;
  logic        a_valid, a_ready;
  logic [2:0]  a_opcode, a_param;
  logic [1:0]  a_size;
  logic [11:0] a_source;
  logic [14:0] a_address;
  logic [3:0]  a_mask;
  logic        a_corrupt;
  logic [31:0] a_data;
  logic        oa_valid, oa_ready;
  logic [2:0]  oa_opcode, oa_param;
  logic [1:0]  oa_size;
  logic [11:0] oa_source;
  logic [14:0] oa_address;
  logic [3:0]  oa_mask;
  logic        oa_corrupt;
  logic [31:0] oa_data;
  logic        od_valid, od_ready;
  logic [2:0]  od_opcode;
  logic [1:0]  od_size;
  logic [11:0] od_source;
  logic [31:0] od_data;
  logic        od_denied;
  logic        id_valid, id_ready;
  logic [2:0]  id_opcode;
  logic [1:0]  id_size;
  logic [11:0] id_source;
  logic [31:0] id_data;
  logic        id_denied;
  logic        busy, err;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;
  logic [71:0] a_q [$];
  logic [49:0] d_q [$];

`ifdef TL_REQ_BUFFER_ERRFLAG_EN
  localparam logic       EXP_ERR  = 1'b1;
  localparam logic [1:0] EXP_CODE = 2'd2;
`else
  localparam logic       EXP_ERR  = 1'b0;
  localparam logic [1:0] EXP_CODE = 2'd0;
`endif

  tl_ul_req_buffer #(.DEPTH(2), .MAX_INFLIGHT(4)) dut (
    .clock(clock), .reset(reset),
    .auto_in_a_valid(a_valid), .auto_in_a_ready(a_ready),
    .auto_in_a_bits_opcode(a_opcode), .auto_in_a_bits_param(a_param),
    .auto_in_a_bits_size(a_size), .auto_in_a_bits_source(a_source),
    .auto_in_a_bits_address(a_address), .auto_in_a_bits_mask(a_mask),
    .auto_in_a_bits_corrupt(a_corrupt), .auto_in_a_bits_data(a_data),
    .auto_out_a_valid(oa_valid), .auto_out_a_ready(oa_ready),
    .auto_out_a_bits_opcode(oa_opcode), .auto_out_a_bits_param(oa_param),
    .auto_out_a_bits_size(oa_size), .auto_out_a_bits_source(oa_source),
    .auto_out_a_bits_address(oa_address), .auto_out_a_bits_mask(oa_mask),
    .auto_out_a_bits_corrupt(oa_corrupt), .auto_out_a_bits_data(oa_data),
    .auto_out_d_valid(od_valid), .auto_out_d_ready(od_ready),
    .auto_out_d_bits_opcode(od_opcode), .auto_out_d_bits_size(od_size),
    .auto_out_d_bits_source(od_source), .auto_out_d_bits_data(od_data),
    .auto_out_d_bits_denied(od_denied),
    .auto_in_d_valid(id_valid), .auto_in_d_ready(id_ready),
    .auto_in_d_bits_opcode(id_opcode), .auto_in_d_bits_size(id_size),
    .auto_in_d_bits_source(id_source), .auto_in_d_bits_data(id_data),
    .auto_in_d_bits_denied(id_denied),
    .busy(busy), .err(err), .err_code(err_code)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one A beat and hold it until accepted; expected beat is queued on acceptance.
  task automatic send_a(input logic [2:0] op, input logic [11:0] src, input logic [14:0] addr,
                        input logic [1:0] sz, input logic [31:0] dat);
    int n = 0;
    logic ok = 1'b0;
    a_valid = 1'b1; a_opcode = op; a_param = 3'd0; a_size = sz; a_source = src;
    a_address = addr; a_mask = src[3:0]; a_corrupt = src[0]; a_data = dat;
    while (!ok && n <= 50) begin
      @(negedge clock);
      if (a_ready) ok = 1'b1;
      else n++;
    end
    if (ok) a_q.push_back({op, 3'd0, sz, src, addr, src[3:0], src[0], dat});
    else begin
      checks++; errors++;
      $display("FAIL a_accept_timeout: src %0h never accepted", src);
    end
    @(posedge clock); #1;
    a_valid = 1'b0;
  endtask

  task automatic send_d(input logic [11:0] src, input logic [31:0] dat);
    int n = 0;
    logic ok = 1'b0;
    od_valid = 1'b1; od_opcode = 3'd1; od_size = 2'd2; od_source = src;
    od_data = dat; od_denied = dat[0];
    while (!ok && n <= 50) begin
      @(negedge clock);
      if (od_ready) ok = 1'b1;
      else n++;
    end
    if (ok) d_q.push_back({3'd1, 2'd2, src, dat, dat[0]});
    else begin
      checks++; errors++;
      $display("FAIL d_accept_timeout: src %0h never accepted", src);
    end
    @(posedge clock); #1;
    od_valid = 1'b0;
  endtask

  task automatic drain_d(input int n, input logic [11:0] base);
    for (int i = 0; i < n; i++) send_d(base + 12'(i), 32'h1000_0000 + i);
    repeat (2) @(posedge clock);
    #1;
  endtask

  // Monitor: every output fire pops and compares the oldest expected beat.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && oa_valid && oa_ready) begin
        if (a_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected: src %0h with nothing expected", oa_source);
        end else
          chk("a_beat", {oa_opcode, oa_param, oa_size, oa_source, oa_address, oa_mask,
                         oa_corrupt, oa_data}, a_q.pop_front());
      end
      if (!reset && id_valid && id_ready) begin
        if (d_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL d_unexpected: src %0h with nothing expected", id_source);
        end else
          chk("d_beat", {22'd0, id_opcode, id_size, id_source, id_data, id_denied},
              {22'd0, d_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; a_valid = 1'b0; oa_ready = 1'b0; od_valid = 1'b0; id_ready = 1'b0;
    a_opcode = '0; a_param = '0; a_size = '0; a_source = '0; a_address = '0;
    a_mask = '0; a_corrupt = 1'b0; a_data = '0;
    od_opcode = '0; od_size = '0; od_source = '0; od_data = '0; od_denied = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_out_a_valid", oa_valid, 0);
    chk("rst_in_d_valid", id_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_a_ready", a_ready, 1);
    chk("rst_err", err, 0);
    chk("rst_err_code", err_code, 0);

    // Back-to-back Gets: each on out_a the cycle after its fire.
    oa_ready = 1'b1; id_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      send_a(3'd4, 12'(i), 15'(i * 4), 2'd2, 32'hA000_0000 + i);
      chk("b2b_latency_valid", oa_valid, 1);
      chk("b2b_latency_src", oa_source, 72'(i));
    end
    @(posedge clock); #1;
    chk("b2b_inflight", dut.r_inflight, 3);
    chk("b2b_out_valid_idle", oa_valid, 0);
    drain_d(3, 12'h001);
    chk("b2b_busy_cleared", busy, 0);

    // Full FIFO backpressure, no bypass.
    oa_ready = 1'b0;
    send_a(3'd4, 12'h011, 15'h0010, 2'd2, 32'h1111_0011);
    send_a(3'd1, 12'h012, 15'h0014, 2'd2, 32'h2222_0012);
    chk("full_in_a_ready", a_ready, 0);
    chk("full_head_src", oa_source, 12'h011);
    fork
      send_a(3'd0, 12'h013, 15'h0018, 2'd2, 32'h3333_0013);
      begin
        repeat (2) @(posedge clock);
        #1;
        chk("full_hold_ready", a_ready, 0);
        chk("full_head_stable", {oa_source, oa_data}, {12'h011, 32'h1111_0011});
        oa_ready = 1'b1;
        @(negedge clock);
        chk("full_no_bypass", a_ready, 0);
      end
    join
    repeat (4) @(posedge clock);
    #1;
    drain_d(3, 12'h011);

    // In-flight limit of 4 holds the 5th request.
    for (int i = 1; i <= 5; i++) send_a(3'd4, 12'h020 + 12'(i), 15'(i * 4), 2'd2, 32'hB000_0000 + i);
    @(posedge clock); #1;
    chk("limit_out_valid_held", oa_valid, 0);
    chk("limit_busy", busy, 1);
    send_d(12'h021, 32'h5555_0021);
    chk("limit_still_held", oa_valid, 0);
    @(posedge clock); #1;
    chk("limit_released_valid", oa_valid, 1);
    chk("limit_released_src", oa_source, 12'h025);
    @(posedge clock); #1;
    drain_d(4, 12'h022);

    // D register hold and no-bubble replace.
    send_a(3'd4, 12'h031, 15'h0030, 2'd2, 32'h0);
    send_a(3'd4, 12'h032, 15'h0034, 2'd2, 32'h0);
    repeat (2) @(posedge clock);
    #1 id_ready = 1'b0;
    send_d(12'h031, 32'hDEADBEEF);
    chk("dreg_valid", id_valid, 1);
    chk("dreg_data", id_data, 32'hDEADBEEF);
    chk("dreg_out_d_ready_low", od_ready, 0);
    repeat (3) @(posedge clock);
    #1;
    chk("dreg_data_stable", {id_source, id_data}, {12'h031, 32'hDEADBEEF});
    chk("dreg_still_blocked", od_ready, 0);
    od_valid = 1'b1; od_opcode = 3'd1; od_size = 2'd2; od_source = 12'h032;
    od_data = 32'hCAFEF00D; od_denied = 1'b1; id_ready = 1'b1;
    @(negedge clock);
    chk("dreg_replace_ready", od_ready, 1);
    if (od_ready) d_q.push_back({3'd1, 2'd2, 12'h032, 32'hCAFEF00D, 1'b1});
    @(posedge clock); #1;
    od_valid = 1'b0;
    chk("dreg_no_bubble_valid", id_valid, 1);
    chk("dreg_no_bubble_data", id_data, 32'hCAFEF00D);
    @(posedge clock); #1;
    chk("dreg_drained", id_valid, 0);
    chk("dreg_busy_clear", busy, 0);

    // Protocol errors: misaligned Put, then illegal opcode must not overwrite the cause.
    send_a(3'd0, 12'h041, 15'h0002, 2'd2, 32'h1234_5678);
    chk("err_set", err, EXP_ERR);
    chk("err_code_misalign", err_code, EXP_CODE);
    send_a(3'd7, 12'h042, 15'h0000, 2'd2, 32'h8765_4321);
    @(posedge clock); #1;
    chk("err_sticky", err, EXP_ERR);
    chk("err_code_first_only", err_code, EXP_CODE);
    drain_d(2, 12'h041);

    // Reset mid-transaction discards buffered A and D beats.
    oa_ready = 1'b0; id_ready = 1'b0;
    send_a(3'd4, 12'h051, 15'h0050, 2'd2, 32'h0);
    send_a(3'd4, 12'h052, 15'h0054, 2'd2, 32'h0);
    send_d(12'h051, 32'h7777_0051);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_d_full", id_valid, 1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    a_q.delete(); d_q.delete();
    chk("mid_rst_out_a_valid", oa_valid, 0);
    chk("mid_rst_in_d_valid", id_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_a_ready", a_ready, 1);
    chk("mid_rst_err", err, 0);
    oa_ready = 1'b1; id_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("post_rst_quiet", {oa_valid, id_valid}, 0);
    chk("a_queue_empty", a_q.size(), 0);
    chk("d_queue_empty", d_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
